count_to_sync: RTL
==================

// Module: count_to_sync
// PURPOSE
//  VGA timing transmitter. Free-running col/row counters generate data-enable style
//  syncs (ohsync/ovsync high over the active area; ovsync rise = frame start), the form
//  sync_to_count consumes. Also emits porch-shaped VGA hsync/vsync and blanked RGB,
//  delay-matched to the upstream pixel generator. Sits between the pattern generator and the pins.
// PARAMETERS
//  TOTAL_COLS      800  pixels per line incl. blanking (<=1024)
//  TOTAL_ROWS      525  lines per frame incl. blanking (<=1024)
//  ACTIVE_COLS     640  visible pixels per line
//  ACTIVE_ROWS     480  visible lines per frame
//  H_FRONT_PORCH   16   pixels from end of active to hsync pulse
//  H_SYNC_WIDTH    96   hsync pulse width, pixels
//  V_FRONT_PORCH   10   lines from end of active to vsync pulse
//  V_SYNC_WIDTH    2    vsync pulse width, lines
//  SYNC_POLARITY   0    asserted level of vga_hs/vga_vs (0 = active low)
//  PIXEL_LATENCY   2    enabled cycles from col/row out to matching ipixel in (0..8)
//  COLOR_BITS      3    bits per colour channel
// PORTS
//  clock        in   1             pixel-domain clock
//  reset        in   1             asynchronous, active-high
//  enable       in   1             pixel strobe; all state advances only when high
//  ohsync       out  1             high while col < ACTIVE_COLS
//  ovsync       out  1             high while row < ACTIVE_ROWS
//  col          out  10            current pixel column
//  row          out  10            current line
//  frame_start  out  1             one-clock pulse when counters enter (0,0)
//  ipixel       in   3*COLOR_BITS  {r,g,b} for col/row issued PIXEL_LATENCY enables earlier
//  vga_hs       out  1             porch-shaped hsync, SYNC_POLARITY when asserted
//  vga_vs       out  1             porch-shaped vsync
//  opixel       out  3*COLOR_BITS  ipixel registered; 0 outside active area
// BEHAVIOUR
//  - Reset (async, immediate): col=TOTAL_COLS-1, row=TOTAL_ROWS-1, ohsync=ovsync=0,
//    frame_start=0, vga_hs/vga_vs=~SYNC_POLARITY, opixel=0, delay line flushed to blank.
//  - First enabled cycle after reset: col=0,row=0, ohsync=ovsync=1, frame_start=1.
//  - Enabled cycle: col+1; at col==TOTAL_COLS-1 -> col=0 and row+1; at row==TOTAL_ROWS-1
//    with col wrap -> row=0. enable low: every register holds; frame_start forced 0.
//  - All outputs registered; ohsync/ovsync/frame_start valid same cycle as the col/row
//    they describe (decoded from next-state values).
//  - H pulse asserted for col in [ACTIVE_COLS+H_FRONT_PORCH, +H_SYNC_WIDTH); V pulse for
//    row in same form. Back porch is the remainder of TOTAL_*.
//  - vga_hs, vga_vs and active flag (ohsync&ovsync) pass through a delay line of
//    PIXEL_LATENCY enabled stages plus one output register: net lag PIXEL_LATENCY+1
//    enables behind col/row. opixel = delayed_active ? ipixel : 0, registered in that
//    same final stage, so vga_hs/vga_vs/opixel are mutually aligned.
//  - Comparisons at 10 bits unsigned; TOTAL_*>1024 or porch+sync+active>TOTAL_* is a
//    configuration error (elaboration-time $error).
// STRUCTURE
//  - Include vga_timing.vh: 640x480@60 defaults above, shared with sync_to_count users.
//  - One sub-module: sync_delay_line (parameterised DEPTH/WIDTH, enable-gated shift
//    register, async reset to a parameter RESET_VALUE); DEPTH=0 is a wire.
//  - Top: counter block, decode block, delay line, output register.
// TESTING
//  1 reset release, enable=1 -> 1st cycle col=0,row=0,frame_start=1; ohsync drops at col=640.
//  2 free run -> col 799->0 with row+1; (799,524)->(0,0), frame_start every 420000 cycles.
//  3 PIXEL_LATENCY=2 -> vga_hs low 96 cycles for col 656..751 and vga_vs low rows 490..491,
//    each 3 enables after the col/row.
//  4 enable 1-of-2 -> counts advance only on strobes; frame period 840000 clocks; no glitches.
//  5 ipixel=9'h1FF constant -> opixel 9'h1FF for 640x480 active, 0 in all blanking.
//  6 async reset at col=300,row=100 (mid-clock) -> outputs at reset values without clock;
//    loopback ohsync/ovsync into sync_to_count, which tracks col/row one clock behind.

Source files
------------

// File: rtl/count_to_sync_pkg.sv
// Shared VGA timing defaults (640x480@60) and small decode helpers for count_to_sync.
package count_to_sync_pkg;

  localparam int DEF_TOTAL_COLS    = 800;
  localparam int DEF_TOTAL_ROWS    = 525;
  localparam int DEF_ACTIVE_COLS   = 640;
  localparam int DEF_ACTIVE_ROWS   = 480;
  localparam int DEF_H_FRONT_PORCH = 16;
  localparam int DEF_H_SYNC_WIDTH  = 96;
  localparam int DEF_V_FRONT_PORCH = 10;
  localparam int DEF_V_SYNC_WIDTH  = 2;
  localparam int DEF_PIXEL_LATENCY = 2;
  localparam int DEF_COLOR_BITS    = 3;
  localparam int COUNT_W           = 10;

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } sync_flags_t;

  // 11-bit sum so a window ending exactly at 1024 does not wrap.
  function automatic logic in_window(logic [COUNT_W-1:0] v,
                                     logic [COUNT_W-1:0] lo,
                                     logic [COUNT_W-1:0] width);
    return ({1'b0, v} >= {1'b0, lo}) && ({1'b0, v} < ({1'b0, lo} + {1'b0, width}));
  endfunction

endpackage

// File: rtl/count_to_sync_delay.sv
// Enable-gated shift register; DEPTH=0 degenerates to a wire.
module sync_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VALUE;
        end else if (enable) begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/count_to_sync.sv
// VGA timing transmitter: col/row counters, data-enable syncs, porch-shaped
// hsync/vsync and blanked RGB aligned to an upstream pixel pipeline.
module count_to_sync
  import count_to_sync_pkg::*;
#(
  parameter int   TOTAL_COLS    = DEF_TOTAL_COLS,
  parameter int   TOTAL_ROWS    = DEF_TOTAL_ROWS,
  parameter int   ACTIVE_COLS   = DEF_ACTIVE_COLS,
  parameter int   ACTIVE_ROWS   = DEF_ACTIVE_ROWS,
  parameter int   H_FRONT_PORCH = DEF_H_FRONT_PORCH,
  parameter int   H_SYNC_WIDTH  = DEF_H_SYNC_WIDTH,
  parameter int   V_FRONT_PORCH = DEF_V_FRONT_PORCH,
  parameter int   V_SYNC_WIDTH  = DEF_V_SYNC_WIDTH,
  parameter logic SYNC_POLARITY = 1'b0,
  parameter int   PIXEL_LATENCY = DEF_PIXEL_LATENCY,
  parameter int   COLOR_BITS    = DEF_COLOR_BITS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  output logic                    ohsync,
  output logic                    ovsync,
  output logic [9:0]              col,
  output logic [9:0]              row,
  output logic                    frame_start,
  input  logic [3*COLOR_BITS-1:0] ipixel,
  output logic                    vga_hs,
  output logic                    vga_vs,
  output logic [3*COLOR_BITS-1:0] opixel
);

  generate
    if (TOTAL_COLS > 1024 || TOTAL_ROWS > 1024 ||
        ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH > TOTAL_COLS ||
        ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH > TOTAL_ROWS ||
        PIXEL_LATENCY < 0 || PIXEL_LATENCY > 8) begin : g_cfg_err
      $error("count_to_sync: inconsistent timing parameters");
    end
  endgenerate

  localparam logic [9:0] LAST_COL = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] LAST_ROW = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] ACT_COLS = 10'(ACTIVE_COLS);
  localparam logic [9:0] ACT_ROWS = 10'(ACTIVE_ROWS);
  localparam logic [9:0] H_START  = 10'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [9:0] H_WIDTH  = 10'(H_SYNC_WIDTH);
  localparam logic [9:0] V_START  = 10'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [9:0] V_WIDTH  = 10'(V_SYNC_WIDTH);

  logic [9:0]  col_nx, row_nx;
  sync_flags_t flags_now, flags_dly;

  // Counter block: next-state values also feed the same-cycle decodes.
  always_comb begin
    col_nx = (col == LAST_COL) ? '0 : col + 10'd1;
    row_nx = row;
    if (col == LAST_COL) row_nx = (row == LAST_ROW) ? '0 : row + 10'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col         <= LAST_COL;
      row         <= LAST_ROW;
      ohsync      <= 1'b0;
      ovsync      <= 1'b0;
      frame_start <= 1'b0;
    end else if (enable) begin
      col         <= col_nx;
      row         <= row_nx;
      ohsync      <= (col_nx < ACT_COLS);
      ovsync      <= (row_nx < ACT_ROWS);
      frame_start <= (col_nx == '0) && (row_nx == '0);
    end else begin
      frame_start <= 1'b0;
    end
  end

  // Decode block: flags describe the col/row currently on the outputs.
  always_comb begin
    flags_now.hs  = in_window(col, H_START, H_WIDTH);
    flags_now.vs  = in_window(row, V_START, V_WIDTH);
    flags_now.act = ohsync & ovsync;
  end

  sync_delay_line #(
    .DEPTH      (PIXEL_LATENCY),
    .WIDTH      (3),
    .RESET_VALUE(3'b000)
  ) u_delay (
    .clock (clock),
    .reset (reset),
    .enable(enable),
    .din   (flags_now),
    .dout  (flags_dly)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vga_hs <= ~SYNC_POLARITY;
      vga_vs <= ~SYNC_POLARITY;
      opixel <= '0;
    end else if (enable) begin
      vga_hs <= flags_dly.hs ? SYNC_POLARITY : ~SYNC_POLARITY;
      vga_vs <= flags_dly.vs ? SYNC_POLARITY : ~SYNC_POLARITY;
      opixel <= flags_dly.act ? ipixel : '0;
    end
  end

endmodule
